// File: rtl/nn_pkg.sv
// Shared definitions for the XOR-network inference sequencer:
// config register indices, FSM state type and the output threshold helper.
package nn_pkg;

  localparam logic [3:0] W11_IDX = 4'd0;
  localparam logic [3:0] W12_IDX = 4'd1;
  localparam logic [3:0] W21_IDX = 4'd2;
  localparam logic [3:0] W22_IDX = 4'd3;
  localparam logic [3:0] B1_IDX  = 4'd4;
  localparam logic [3:0] B2_IDX  = 4'd5;
  localparam logic [3:0] W31_IDX = 4'd6;
  localparam logic [3:0] W32_IDX = 4'd7;
  localparam logic [3:0] B3_IDX  = 4'd8;
  localparam int NUM_CFG_REGS = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  // True when the FP value (zero-extended into 64 bits) is >= 0.5 and not NaN.
  function automatic logic fp_ge_half(input logic [63:0] value, input int exp_w, input int frac_w);
    logic [63:0] exp_mask;
    logic [63:0] frac_mask;
    logic [63:0] exp_f;
    logic [63:0] frac_f;
    logic        sign;
    logic        is_nan;
    exp_mask  = (64'd1 << exp_w) - 64'd1;
    frac_mask = (64'd1 << frac_w) - 64'd1;
    exp_f     = (value >> frac_w) & exp_mask;
    frac_f    = value & frac_mask;
    sign      = |((value >> (exp_w + frac_w)) & 64'd1);
    is_nan    = (exp_f == exp_mask) && (frac_f != 64'd0);
    return !sign && (exp_f >= ((64'd1 << (exp_w - 1)) - 64'd2)) && !is_nan;
  endfunction

endpackage

// File: rtl/nn_cfg_regbank.sv
// Weight/bias register bank: address-checked writes, gated by the sequencer,
// with a registered one-cycle error pulse for rejected writes.
module nn_cfg_regbank
  import nn_pkg::*;
#(
  parameter int FW = 32
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_addr,
  input  logic [FW-1:0]              cfg_wdata,
  input  logic                       wr_allow,
  output logic                       cfg_err,
  output logic [NUM_CFG_REGS*FW-1:0] weights
);

  logic [FW-1:0] regs [NUM_CFG_REGS];
  logic          addr_ok;
  logic          wr_take;

  assign addr_ok = (cfg_addr <= B3_IDX);
  assign wr_take = cfg_we && wr_allow && addr_ok;

  always_ff @(posedge clk) begin
    if (rst_l) begin
      for (int k = 0; k < NUM_CFG_REGS; k++) regs[k] <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !wr_take;
      for (int k = 0; k < NUM_CFG_REGS; k++)
        if (wr_take && (cfg_addr == 4'(k))) regs[k] <= cfg_wdata;
    end
  end

  for (genvar k = 0; k < NUM_CFG_REGS; k++) begin : g_pack
    assign weights[k*FW +: FW] = regs[k];
  end

endmodule

// File: rtl/nn_infer_sequencer.sv
// Transaction controller around the 2-2-1 XOR network: launches a sample,
// waits a fixed settle time, captures and thresholds the result.
//   state   | meaning
//   IDLE    | ready for a sample; config writes allowed
//   SETTLE  | operands held, counting down settle time
//   CAPTURE | register network output, flags and decision
//   HOLD    | result presented until out_ready
module nn_infer_sequencer
  import nn_pkg::*;
#(
  parameter  int exp_width     = 8,
  parameter  int mant_width    = 24,
  parameter  int SETTLE_CYCLES = 8,
  localparam int FW            = exp_width + mant_width
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       cfg_we,
  input  logic [3:0]                 cfg_addr,
  input  logic [FW-1:0]              cfg_wdata,
  output logic                       cfg_err,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FW-1:0]              in_a,
  input  logic [FW-1:0]              in_b,
  input  logic [2:0]                 in_round_mode,
  output logic [NUM_CFG_REGS*FW-1:0] nn_weights,
  output logic [FW-1:0]              nn_a,
  output logic [FW-1:0]              nn_b,
  output logic [2:0]                 nn_round_mode,
  input  logic [FW-1:0]              nn_xor_output,
  input  logic [4:0]                 nn_exceptions,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FW-1:0]              out_value,
  output logic                       out_bit,
  output logic [4:0]                 out_exc,
  output logic                       busy
);

  state_t     state;
  state_t     state_next;
  logic [7:0] cnt;

  // Writes are only taken in IDLE so weights never move under a live sample.
  nn_cfg_regbank #(.FW(FW)) u_regbank (
    .clk       (clk),
    .rst_l     (rst_l),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .wr_allow  (state == ST_IDLE),
    .cfg_err   (cfg_err),
    .weights   (nn_weights)
  );

  always_ff @(posedge clk) begin
    if (rst_l) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (in_valid) state_next = ST_SETTLE;
      ST_SETTLE:  if (cnt == 8'd0) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    if (out_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_l) begin
      cnt           <= '0;
      nn_a          <= '0;
      nn_b          <= '0;
      nn_round_mode <= '0;
      out_value     <= '0;
      out_exc       <= '0;
      out_bit       <= 1'b0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        nn_a          <= in_a;
        nn_b          <= in_b;
        nn_round_mode <= in_round_mode;
        cnt           <= 8'(SETTLE_CYCLES - 1);
      end
      if (state == ST_SETTLE && cnt != 8'd0) cnt <= cnt - 8'd1;
      if (state == ST_CAPTURE) begin
        out_value <= nn_xor_output;
        out_exc   <= nn_exceptions;
        out_bit   <= fp_ge_half(64'(nn_xor_output), exp_width, mant_width - 1);
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_nn_infer_sequencer.sv
// Self-checking bench for nn_infer_sequencer: directed threshold table,
// config/reset/backpressure sequences and randomized transactions.
module tb_nn_infer_sequencer;

  localparam int FW = 32;
  localparam int S  = 8;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          cfg_we;
  logic [3:0]    cfg_addr;
  logic [FW-1:0] cfg_wdata;
  logic          cfg_err;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_a;
  logic [FW-1:0] in_b;
  logic [2:0]    in_round_mode;
  logic [9*FW-1:0] nn_weights;
  logic [FW-1:0] nn_a;
  logic [FW-1:0] nn_b;
  logic [2:0]    nn_round_mode;
  logic [FW-1:0] nn_xor_output;
  logic [4:0]    nn_exceptions;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_value;
  logic          out_bit;
  logic [4:0]    out_exc;
  logic          busy;

  nn_infer_sequencer dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_err       (cfg_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_round_mode (in_round_mode),
    .nn_weights    (nn_weights),
    .nn_a          (nn_a),
    .nn_b          (nn_b),
    .nn_round_mode (nn_round_mode),
    .nn_xor_output (nn_xor_output),
    .nn_exceptions (nn_exceptions),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_value     (out_value),
    .out_bit       (out_bit),
    .out_exc       (out_exc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int accept_cyc = 0;
  logic [31:0] wmodel [9];

  typedef struct {
    logic [31:0] y;
    logic [4:0]  e;
    logic        b;
  } vec_t;
  vec_t tbl [12];

  // Positive floats order like unsigned integers, so >= 0.5 is a magnitude compare.
  function automatic logic ref_bit(input logic [31:0] v);
    logic nan;
    nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    return !v[31] && (v[30:0] >= 31'h3F000000) && !nan;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string name);
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s_w%0d", name, k), 64'(nn_weights[k*32 +: 32]), 64'(wmodel[k]));
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [31:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_round_mode = rm;
    tick;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_round_mode = ~rm;
    accept_cyc = cyc;
    chk("nn_a", 64'(nn_a), 64'(a));
    chk("nn_b", 64'(nn_b), 64'(b));
    chk("nn_round_mode", 64'(nn_round_mode), 64'(rm));
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  task automatic finish_txn(input logic [31:0] y, input logic [4:0] e, input logic eb, input int hold);
    int n;
    logic ok;
    nn_xor_output = y; nn_exceptions = e;
    n = 0;
    while (!out_valid && n < 300) begin tick; n++; end
    chk("latency", 64'(cyc - accept_cyc), 64'(S + 1));
    chk("out_value", 64'(out_value), 64'(y));
    chk("out_bit", 64'(out_bit), 64'(eb));
    chk("out_exc", 64'(out_exc), 64'(e));
    nn_xor_output = ~y; nn_exceptions = ~e;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick;
      if (!out_valid || out_value !== y || out_bit !== eb || out_exc !== e || in_ready) ok = 1'b0;
    end
    chk("hold_stable", 64'(ok), 64'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("out_valid_release", 64'(out_valid), 64'd0);
    chk("in_ready_release", 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] y;
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        ok;

    rst_l = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_round_mode = '0;
    nn_xor_output = '0; nn_exceptions = '0; out_ready = 1'b0;
    for (int k = 0; k < 9; k++) wmodel[k] = '0;

    tbl[0]  = '{32'h3F000000, 5'b00000, 1'b1};
    tbl[1]  = '{32'h3EFFFFFF, 5'b00000, 1'b0};
    tbl[2]  = '{32'hBF400000, 5'b00000, 1'b0};
    tbl[3]  = '{32'h7FC00000, 5'b00001, 1'b0};
    tbl[4]  = '{32'h7F800000, 5'b00000, 1'b1};
    tbl[5]  = '{32'h3F7FFFFF, 5'b00100, 1'b1};
    tbl[6]  = '{32'h80000000, 5'b00000, 1'b0};
    tbl[7]  = '{32'h00000001, 5'b10000, 1'b0};
    tbl[8]  = '{32'h7F800001, 5'b00000, 1'b0};
    tbl[9]  = '{32'hFF800000, 5'b01000, 1'b0};
    tbl[10] = '{32'h3F800000, 5'b00010, 1'b1};
    tbl[11] = '{32'h00000000, 5'b00000, 1'b0};

    tick; tick;
    rst_l = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_nn_a", 64'(nn_a), 64'd0);
    chk("rst_out_value", 64'(out_value), 64'd0);
    check_bank("rst_bank");

    // Threshold table; entry 0 also exercises 20 cycles of backpressure.
    for (int i = 0; i < 12; i++) begin
      accept(32'($urandom), 32'($urandom), 3'($urandom_range(0, 7)));
      finish_txn(tbl[i].y, tbl[i].e, tbl[i].b, (i == 0) ? 20 : i % 3);
    end

    cfg_write(4'd8, 32'h40000000);
    wmodel[8] = 32'h40000000;
    chk("cfg8_err", 64'(cfg_err), 64'd0);
    check_bank("cfg8");

    cfg_write(4'd9, 32'hDEADBEEF);
    chk("cfg9_err", 64'(cfg_err), 64'd1);
    check_bank("cfg9");
    tick;
    chk("cfg9_err_clear", 64'(cfg_err), 64'd0);

    accept(32'h11111111, 32'h22222222, 3'd3);
    tick;
    cfg_write(4'd0, 32'h12345678);
    chk("busy_write_err", 64'(cfg_err), 64'd1);
    check_bank("busy_write");
    tick;
    chk("busy_write_err_clear", 64'(cfg_err), 64'd0);
    finish_txn(32'h3F100000, 5'd0, 1'b1, 1);

    // Write and sample in the same IDLE cycle.
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'h3F800000;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h0; in_round_mode = 3'd1;
    tick;
    cfg_we = 1'b0; in_valid = 1'b0;
    accept_cyc = cyc;
    wmodel[0] = 32'h3F800000;
    chk("simul_cfg_err", 64'(cfg_err), 64'd0);
    chk("simul_nn_a", 64'(nn_a), 64'h3F800000);
    check_bank("simul");
    finish_txn(32'h3E800000, 5'd0, 1'b0, 0);

    // Reset after four settle cycles (counter at 3).
    accept(32'hAAAA5555, 32'h5555AAAA, 3'd2);
    nn_xor_output = 32'h3F800000;
    repeat (4) tick;
    rst_l = 1'b1;
    tick;
    rst_l = 1'b0;
    for (int k = 0; k < 9; k++) wmodel[k] = '0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_nn_a", 64'(nn_a), 64'd0);
    check_bank("midrst");
    ok = 1'b1;
    repeat (15) begin tick; if (out_valid) ok = 1'b0; end
    chk("midrst_no_output", 64'(ok), 64'd1);

    for (int i = 0; i < 25; i++) begin
      ra = 4'($urandom_range(0, 10));
      rd = 32'($urandom);
      cfg_write(ra, rd);
      if (ra <= 4'd8) wmodel[ra] = rd;
      chk("rand_cfg_err", 64'(cfg_err), (ra <= 4'd8) ? 64'd0 : 64'd1);
      check_bank("rand_cfg");
      case ($urandom_range(0, 3))
        0: y = 32'($urandom);
        1: y = 32'h3F000000 - 32'd2 + 32'($urandom_range(0, 4));
        2: y = {1'b1, 31'h3F000000 - 31'd2 + 31'($urandom_range(0, 4))};
        default: y = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(0, 3))};
      endcase
      accept(32'($urandom), 32'($urandom), 3'($urandom_range(0, 7)));
      finish_txn(y, 5'($urandom_range(0, 31)), ref_bit(y), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nn_infer_sequencer.md
Name: nn_infer_sequencer

Overview:
Transaction controller wrapped around the 2-2-1 XOR network datapath.
- Holds the 9 weight/bias words in a configuration register bank.
- Accepts (A,B) samples over a valid/ready handshake and holds operands stable on the network inputs for a fixed settle time covering the combinational FP chain plus the sigmoid latency.
- Then captures the network output and exception flags, thresholds the output at 0.5, and presents the result on a valid/ready output port.

Parameters:
- exp_width, 8, FP exponent width.
- mant_width, 24, FP mantissa width including hidden bit; FW = exp_width+mant_width.
- SETTLE_CYCLES, 8, cycles from operand launch to a valid network output; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_l  in  1  synchronous, active-high reset; rst_l=1 at a rising edge resets.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  4  register index: 0 w11, 1 w12, 2 w21, 3 w22, 4 b1, 5 b2, 6 w31, 7 w32, 8 b3.
- cfg_wdata  in  FW  config write data.
- cfg_err  out  1  one-cycle pulse: write rejected.
- in_valid  in  1  sample offered.
- in_ready  out  1  sample accepted when in_valid&in_ready.
- in_a, in_b  in  FW each  sample operands.
- in_round_mode  in  3  rounding mode for this sample.
- nn_weights  out  9*FW  packed; slice k = register k, k=0 at LSBs.
- nn_a, nn_b  out  FW each  held operands.
- nn_round_mode  out  3  held rounding mode.
- nn_xor_output  in  FW  network result.
- nn_exceptions  in  5  network exception flags.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_value  out  FW  captured network result.
- out_bit  out  1  thresholded XOR decision.
- out_exc  out  5  captured exception flags.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all registers 0; state IDLE; in_ready=1; out_valid=0; cfg_err=0; nn_* outputs 0. Reset mid-transaction abandons the sample with no output.
- FSM states: IDLE, SETTLE, CAPTURE, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_a/in_b/in_round_mode into nn_a/nn_b/nn_round_mode, load cnt=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - cnt decrements each cycle.
  - At cnt==0, go to CAPTURE.
- CAPTURE (one cycle):
  - Register nn_xor_output into out_value and nn_exceptions into out_exc; compute out_bit.
  - Go to HOLD; out_valid=1 from the next cycle.
- HOLD:
  - out_valid=1; outputs stable.
  - On out_ready, go to IDLE with out_valid=0 next cycle.
  - No new sample is accepted in the same cycle (in_ready=0 in HOLD).
- Latency: accept edge at cycle t → out_valid first high at cycle t+SETTLE_CYCLES+1. Minimum throughput is 1 sample per SETTLE_CYCLES+2 cycles.
- out_bit:
  - 1 iff sign=0, exponent field >= 2^(exp_width-1)-2 (i.e. value >= 0.5), and value is not NaN.
  - NaN means exponent all ones with mantissa field nonzero.
  - +Inf gives 1.
  - -0 and denormals give 0.
- Config writes:
  - Accepted only in IDLE with cfg_addr<=8; the register updates at that edge.
  - A write in any other state, or with cfg_addr>8, is ignored and cfg_err pulses for 1 cycle.
  - A write and a sample accept in the same IDLE cycle are both taken; the sample uses the new value.
- Weights and operands never change while busy=1.
- Counter width is 8 bits; no wrap occurs because cnt is only loaded in IDLE.

Decomposition:
- Shared package nn_pkg:
  - register index constants: W11_IDX..B3_IDX, NUM_CFG_REGS=9.
  - state enum typedef.
  - function fp_ge_half(value), parameterised by widths.
- One sub-module, nn_cfg_regbank: 9×FW registers, write decode, address-range check, packed output bus.
- FSM, counter and capture logic live in the top.

Test Plan:
1. Latency: SETTLE_CYCLES=8; stub drives nn_xor_output=0x3F000000; accept at cycle 10 → out_valid rises at cycle 19, out_value=0x3F000000, out_bit=1.
2. Threshold edges: outputs 0x3EFFFFFF → 0; 0xBF400000 → 0; 0x7FC00000 (NaN) → 0; 0x7F800000 → 1; 0x3F7FFFFF → 1; nn_exceptions=5'b00100 → out_exc=5'b00100.
3. Backpressure: hold out_ready=0 for 20 cycles → out_valid and out_value stable, in_ready=0 throughout; out_ready=1 → IDLE next cycle, in_ready=1.
4. Config:
   - Write addr 8 = 0x40000000 in IDLE → nn_weights[8*FW+:FW]=0x40000000.
   - Write during SETTLE → cfg_err one-cycle pulse, bank unchanged.
   - Write addr 9 in IDLE → cfg_err pulse, bank unchanged.
5. Reset mid-SETTLE: assert rst_l=1 one cycle at cnt=3 → next cycle state IDLE, out_valid=0, nn_weights=0, no result emitted.
6. Simultaneous write and sample in IDLE (addr 0 = 0x3F800000 and in_valid with in_a=0x3F800000, in_b=0) → nn_weights slice 0 and nn_a both 0x3F800000 on the next cycle.
